// File: rtl/dpwm_freq_divider.sv
// dpwm_freq_divider: runtime-programmable divisor table plus divide counter
// for a DPWM core. It emits a one-cycle period tick, the active divisor and
// the active select index. Changes to the selection or to the table take
// effect only at a period boundary, so a running period is never cut short
// or stretched.
//
// Optional build macro: SEL_SYNC_EN
//   defined   - sel goes through a 2-flop synchronizer (reset 0) before use
//   undefined - sel is used directly and must already be synchronous to clk
module dpwm_freq_divider #(
  parameter int SEL_W = 3,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             tick,
  output logic [CNT_W-1:0] paradiv,
  output logic [SEL_W-1:0] sel_act,
  output logic [CNT_W-1:0] cnt
);

  localparam int N_SEL = 2 ** SEL_W;

  // Factory divisor for a table slot; every slot past the eighth gets 6.
  function automatic logic [CNT_W-1:0] default_entry(input int idx);
    logic [CNT_W-1:0] val;
    case (idx)
      32'd0:   val = CNT_W'(41);
      32'd1:   val = CNT_W'(25);
      32'd2:   val = CNT_W'(16);
      32'd3:   val = CNT_W'(12);
      32'd4:   val = CNT_W'(10);
      32'd5:   val = CNT_W'(8);
      32'd6:   val = CNT_W'(7);
      default: val = CNT_W'(6);
    endcase
    return val;
  endfunction

  logic [CNT_W-1:0] tbl [N_SEL];
  logic [SEL_W-1:0] sel_use;
  logic [CNT_W-1:0] eff_raw;
  logic [CNT_W-1:0] eff;
  logic             last_cnt;

`ifdef SEL_SYNC_EN
  logic [SEL_W-1:0] sel_meta;
  logic [SEL_W-1:0] sel_sync;

  // Two-stage synchronizer bringing sel into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_meta <= SEL_W'(0);
      sel_sync <= SEL_W'(0);
    end else begin
      sel_meta <= sel;
      sel_sync <= sel_meta;
    end
  end

  assign sel_use = sel_sync;
`else
  assign sel_use = sel;
`endif

  // Divisor table: defaults on reset, single-port write from the config bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SEL; i++) begin
        tbl[i] <= default_entry(i);
      end
    end else if (cfg_we) begin
      tbl[cfg_addr] <= cfg_data;
    end else begin
      tbl[cfg_addr] <= tbl[cfg_addr];
    end
  end

  // Effective divisor lookup; 0 and 1 would give no real period, so clamp to 2.
  always_comb begin
    eff_raw = tbl[sel_use];
    if (eff_raw < CNT_W'(2)) begin
      eff = CNT_W'(2);
    end else begin
      eff = eff_raw;
    end
  end

  // Final count of the running period, derived from registered state only.
  always_comb begin
    if (cnt == (paradiv - CNT_W'(1))) begin
      last_cnt = 1'b1;
    end else begin
      last_cnt = 1'b0;
    end
  end

  // Tick is only meaningful while counting; idle keeps it low.
  always_comb begin
    if (en) begin
      tick = last_cnt;
    end else begin
      tick = 1'b0;
    end
  end

  // Divide counter. Idle tracks the selection each cycle; running reloads
  // divisor and select only on the last count of a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= CNT_W'(0);
      paradiv <= CNT_W'(41);
      sel_act <= SEL_W'(0);
    end else if (!en) begin
      cnt     <= CNT_W'(0);
      paradiv <= eff;
      sel_act <= sel_use;
    end else if (last_cnt) begin
      cnt     <= CNT_W'(0);
      paradiv <= eff;
      sel_act <= sel_use;
    end else begin
      cnt     <= cnt + CNT_W'(1);
      paradiv <= paradiv;
      sel_act <= sel_act;
    end
  end

endmodule

// File: tb/tb_dpwm_freq_divider.sv
// Scoreboard bench for dpwm_freq_divider: the driver pushes the expected
// per-cycle outputs from a period-level reference model; an independent
// monitor pops and compares on every falling edge.
module tb_dpwm_freq_divider;

  localparam int SEL_W = 3;
  localparam int CNT_W = 7;
  localparam int N_SEL = 2 ** SEL_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [SEL_W-1:0] sel = '0;
  logic             cfg_we = 1'b0;
  logic [SEL_W-1:0] cfg_addr = '0;
  logic [CNT_W-1:0] cfg_data = '0;
  logic             tick;
  logic [CNT_W-1:0] paradiv;
  logic [SEL_W-1:0] sel_act;
  logic [CNT_W-1:0] cnt;

  dpwm_freq_divider #(.SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sel(sel),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .tick(tick), .paradiv(paradiv), .sel_act(sel_act), .cnt(cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             tick;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [SEL_W-1:0] sel;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: a period is m_div cycles long, m_phase cycles into it.
  int m_tbl[N_SEL];
  int m_div, m_sel, m_phase;
  int h1, h2;  // sel history used when the synchronizer is built in

  function automatic int def_val(int i);
    int d[8] = '{41, 25, 16, 12, 10, 8, 7, 6};
    return (i < 8) ? d[i] : 6;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N_SEL; i++) m_tbl[i] = def_val(i);
    m_div = 41; m_sel = 0; m_phase = 0; h1 = 0; h2 = 0;
  endfunction

  // One rising edge with the inputs present during the cycle that just ended.
  function automatic void model_advance();
    int s, d;
`ifdef SEL_SYNC_EN
    s = h2;
    h2 = h1;
    h1 = int'(sel);
`else
    s = int'(sel);
`endif
    d = (m_tbl[s] < 2) ? 2 : m_tbl[s];
    if (!en || m_phase == m_div - 1) begin
      m_div = d; m_sel = s; m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
    end
    if (cfg_we) m_tbl[int'(cfg_addr)] = int'(cfg_data);
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.tick = rst_n && en && (m_phase == m_div - 1);
    e.cnt  = CNT_W'(m_phase);
    e.div  = CNT_W'(m_div);
    e.sel  = SEL_W'(m_sel);
    exp_q.push_back(e);
  endfunction

  task automatic tick_edge();
    @(posedge clk);
    #1;
    if (rst_n) model_advance();
  endtask

  task automatic drive(input logic e, input logic [SEL_W-1:0] s, input logic we,
                       input logic [SEL_W-1:0] a, input logic [CNT_W-1:0] d);
    rst_n = 1'b1; en = e; sel = s; cfg_we = we; cfg_addr = a; cfg_data = d;
    push_exp();
  endtask

  task automatic run(input logic e, input logic [SEL_W-1:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      tick_edge();
      drive(e, s, 1'b0, '0, '0);
    end
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick_edge();
      rst_n = 1'b0; cfg_we = 1'b0;
      model_reset();
      push_exp();
    end
  endtask

  // Run until the model reaches (div,phase); an expired budget is a failure.
  task automatic run_until(input logic [SEL_W-1:0] s, input int div, input int ph,
                           input string name);
    int n = 0;
    while (!(m_div == div && m_phase == ph) && n < 600) begin
      run(1'b1, s, 1);
      n++;
    end
    if (n >= 600) begin
      vectors++; miscompares++;
      $display("FAIL %s: position div=%0d phase=%0d not reached", name, div, ph);
    end
  endtask

  // Monitor: compare DUT outputs to the oldest expectation every falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (tick !== e.tick || cnt !== e.cnt || paradiv !== e.div || sel_act !== e.sel) begin
          miscompares++;
          $display("FAIL cycle_out t=%0t: got tick=%0b cnt=%0d paradiv=%0d sel_act=%0d, want tick=%0b cnt=%0d paradiv=%0d sel_act=%0d",
                   $time, tick, cnt, paradiv, sel_act, e.tick, e.cnt, e.div, e.sel);
        end
      end
    end
  end

  initial begin
    int n;
    logic [SEL_W-1:0] rs;
    model_reset();
    reset_cycles(3);

    // Power-on run on sel 0: ticks every 41 cycles.
    run(1'b1, 3'd0, 130);

    // Select change mid-period waits for the boundary.
    run_until(3'd0, 41, 10, "sel_midperiod");
    run(1'b1, 3'd7, 60);

    // Idle write of 1 to the selected entry is clamped to 2.
    tick_edge(); drive(1'b0, 3'd2, 1'b1, 3'd2, 7'd1);
    run(1'b0, 3'd2, 4);
    run(1'b1, 3'd2, 12);

    // Write on the boundary cycle: next period keeps 8, the one after uses 20.
    run(1'b1, 3'd5, 3);
    n = 0;
    forever begin
      tick_edge();
      if ((m_sel == 5 && m_phase == m_div - 1) || n >= 100) break;
      drive(1'b1, 3'd5, 1'b0, '0, '0);
      n++;
    end
    drive(1'b1, 3'd5, 1'b1, 3'd5, 7'd20);
    if (n >= 100) begin
      vectors++; miscompares++;
      $display("FAIL boundary_write: boundary not reached");
    end
    run(1'b1, 3'd5, 45);

    // Abandon a div-16 period at cnt 3, then restart.
    tick_edge(); drive(1'b1, 3'd2, 1'b1, 3'd2, 7'd16);
    run_until(3'd2, 16, 3, "abandon");
    run(1'b0, 3'd2, 3);
    run(1'b1, 3'd2, 20);

    // Reset mid-period after rewriting entry 0 to 50.
    tick_edge(); drive(1'b1, 3'd0, 1'b1, 3'd0, 7'd50);
    run_until(3'd0, 50, 20, "reset_mid");
    reset_cycles(2);
    run(1'b1, 3'd0, 90);

    // Longest divisor: counter reaches 126 and wraps cleanly.
    tick_edge(); drive(1'b1, 3'd3, 1'b1, 3'd3, 7'd127);
    run(1'b1, 3'd3, 270);

    // Randomized traffic with small divisors, including 0 and 1.
    rs = 3'd0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) rs = SEL_W'($urandom_range(0, N_SEL - 1));
      tick_edge();
      if ($urandom_range(0, 9) == 0)
        drive($urandom_range(0, 15) != 0, rs, 1'b1, SEL_W'($urandom_range(0, N_SEL - 1)),
              CNT_W'($urandom_range(0, 24)));
      else
        drive($urandom_range(0, 15) != 0, rs, 1'b0, '0, '0);
    end

    tick_edge(); drive(1'b0, 3'd0, 1'b0, '0, '0);
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
